dbg_arbiter: RTL

DBG_ARBITER -- requirements
Module: dbg_arbiter

---
 rtl/dbg_arb_pkg.sv | 13 +
 rtl/dbg_arb_timeout.sv | 32 +++
 rtl/dbg_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dbg_arb_pkg.sv
// Shared types for the two-port debug bus arbiter.
// Holds the FSM state encoding and the grant index type.
package dbg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic gnt_t;

endpackage

// File: rtl/dbg_arb_timeout.sv
// Saturating transfer watchdog; expired flags the cycle the count hits TIMEOUT.
// A TIMEOUT of zero disables expiry entirely.
module dbg_arb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit ON = (TIMEOUT != 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && cnt != MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = ON && enable && (cnt == LAST);

endmodule

// File: rtl/dbg_arbiter.sv
// Round-robin arbiter giving two debug requesters access to the CPU debug bus,
// plus breakpoint latch and stall combining.
module dbg_arbiter
    import dbg_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_stb_i,
    input  logic                  req0_we_i,
    input  logic [ADDR_WIDTH-1:0] req0_adr_i,
    input  logic [DATA_WIDTH-1:0] req0_dat_i,
    output logic [DATA_WIDTH-1:0] req0_dat_o,
    output logic                  req0_ack_o,
    output logic                  req0_err_o,
    input  logic                  req0_stall_i,
    input  logic                  req0_unstall_i,
    input  logic                  req1_stb_i,
    input  logic                  req1_we_i,
    input  logic [ADDR_WIDTH-1:0] req1_adr_i,
    input  logic [DATA_WIDTH-1:0] req1_dat_i,
    output logic [DATA_WIDTH-1:0] req1_dat_o,
    output logic                  req1_ack_o,
    output logic                  req1_err_o,
    input  logic                  req1_stall_i,
    input  logic                  req1_unstall_i,
    input  logic                  cpu_bp_i,
    output logic                  cpu_stall_o,
    output logic                  cpu_stb_o,
    output logic                  cpu_we_o,
    output logic [ADDR_WIDTH-1:0] cpu_adr_o,
    output logic [DATA_WIDTH-1:0] cpu_dat_o,
    input  logic [DATA_WIDTH-1:0] cpu_dat_i,
    input  logic                  cpu_ack_i,
    output logic                  bp_hit_o
);

    state_t state, state_nxt;
    gnt_t   gnt, last, pick;
    logic   any_req, expired;
    logic [DATA_WIDTH-1:0] rdat [2];
    logic [1:0] ack, err;

    assign any_req = req0_stb_i | req1_stb_i;

    // On contention favour whoever was not served last
    always_comb begin
        pick = req1_stb_i;
        if (req0_stb_i && req1_stb_i) pick = ~last;
    end

    dbg_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != XFER),
        .enable  ((state == XFER) && !cpu_ack_i),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = XFER;
            XFER:    if (cpu_ack_i || expired) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt       <= 1'b0;
            last      <= 1'b1;
            cpu_stb_o <= 1'b0;
            cpu_we_o  <= 1'b0;
            cpu_adr_o <= '0;
            cpu_dat_o <= '0;
            rdat[0]   <= '0;
            rdat[1]   <= '0;
            ack       <= '0;
            err       <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            case (state)
                IDLE: if (any_req) begin
                    gnt       <= pick;
                    last      <= pick;
                    cpu_stb_o <= 1'b1;
                    cpu_we_o  <= pick ? req1_we_i  : req0_we_i;
                    cpu_adr_o <= pick ? req1_adr_i : req0_adr_i;
                    cpu_dat_o <= pick ? req1_dat_i : req0_dat_i;
                end
                XFER: if (cpu_ack_i) begin
                    cpu_stb_o <= 1'b0;
                    cpu_we_o  <= 1'b0;
                    if (!cpu_we_o) rdat[gnt] <= cpu_dat_i;
                    ack[gnt]  <= 1'b1;
                end else if (expired) begin
                    cpu_stb_o <= 1'b0;
                    cpu_we_o  <= 1'b0;
                    rdat[gnt] <= '0;
                    ack[gnt]  <= 1'b1;
                    err[gnt]  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req0_dat_o = rdat[0];
    assign req1_dat_o = rdat[1];
    assign req0_ack_o = ack[0];
    assign req1_ack_o = ack[1];
    assign req0_err_o = err[0];
    assign req1_err_o = err[1];

    // A simultaneous new breakpoint outranks the unstall
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                bp_hit_o <= 1'b0;
        else if (cpu_bp_i)                      bp_hit_o <= 1'b1;
        else if (req0_unstall_i | req1_unstall_i) bp_hit_o <= 1'b0;
    end

    assign cpu_stall_o = cpu_bp_i | bp_hit_o | req0_stall_i | req1_stall_i;

endmodule
